// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - reads a message from word memory and streams it padded into 16-word blocks
// Each stream word is fetched or synthesized, then held on blk_* until the downstream handshake.
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic [31:0] blk_word,
  output logic [3:0]  blk_idx,
  output logic        blk_last,
  output logic        msg_last
);

  localparam int          NUM_BLOCKS = (32 * NUM_OF_WORDS + 64) / 512 + 1;
  localparam logic [15:0] MSG_WORDS  = 16'(NUM_OF_WORDS);
  localparam logic [15:0] LAST_W     = 16'(16 * NUM_BLOCKS - 1);
  localparam logic [15:0] LEN_HI_W   = 16'(16 * NUM_BLOCKS - 2);
  localparam logic [63:0] MSG_BITS   = 64'(NUM_OF_WORDS) * 64'd32;

  typedef enum logic [1:0] {IDLE, REQ, CAP, EMIT} state_t;

  state_t      state;
  logic [15:0] w;
  logic [15:0] base_addr;
  logic [15:0] w_next;
  logic [31:0] pad_word;

  assign mem_clk = clk;
  assign mem_we  = 1'b0;
  assign w_next  = w + 16'd1;

  // Words past the message: one marker word, zeros, then the 64-bit bit count.
  always_comb begin
    pad_word = 32'h0;
    if (w == MSG_WORDS)     pad_word = 32'h8000_0000;
    else if (w == LEN_HI_W) pad_word = MSG_BITS[63:32];
    else if (w == LAST_W)   pad_word = MSG_BITS[31:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      w         <= 16'h0;
      base_addr <= 16'h0;
      mem_addr  <= 16'h0;
      done      <= 1'b0;
      blk_valid <= 1'b0;
      blk_word  <= 32'h0;
      blk_idx   <= 4'h0;
      blk_last  <= 1'b0;
      msg_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_addr <= message_addr;
            w         <= 16'h0;
            // Address is presented during REQ so the synchronous read lands in CAP.
            mem_addr  <= message_addr;
            state     <= REQ;
          end
        end
        REQ: begin
          mem_addr <= 16'h0;
          if (w < MSG_WORDS) begin
            state <= CAP;
          end else begin
            blk_word  <= pad_word;
            blk_valid <= 1'b1;
            blk_idx   <= w[3:0];
            blk_last  <= &w[3:0];
            msg_last  <= (w == LAST_W);
            state     <= EMIT;
          end
        end
        CAP: begin
          blk_word  <= mem_read_data;
          blk_valid <= 1'b1;
          blk_idx   <= w[3:0];
          blk_last  <= &w[3:0];
          msg_last  <= (w == LAST_W);
          state     <= EMIT;
        end
        EMIT: begin
          if (blk_ready) begin
            blk_valid <= 1'b0;
            if (w == LAST_W) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              w        <= w_next;
              mem_addr <= (w_next < MSG_WORDS) ? base_addr + w_next : 16'h0;
              state    <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Upstream feeder for the SHA-256 block-expansion/compression stage. Reads a NUM_OF_WORDS-word message from the shared word-addressed memory and emits a padded message stream of 16-word (512-bit) blocks, one 32-bit word per valid/ready handshake. Padding follows FIPS 180-4: one 0x80000000 word, zero words, then the 64-bit message bit length. The downstream hash core consumes this stream and no longer performs its own padding.

## Interface
- NUM_OF_WORDS, 20, message length in 32-bit words; legal range 1..4096.
- clk  in  1  single clock for all logic; also driven out as mem_clk.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- message_addr  in  16  word address of message word 0; latched on accepted start.
- done  out  1  one-cycle pulse after the final stream word handshakes.
- mem_clk  out  1  equals clk.
- mem_we  out  1  tied 0; this block never writes memory.
- mem_addr  out  16  read address.
- mem_read_data  in  32  synchronous memory read data, valid one cycle after the address.
- blk_valid  out  1  blk_word and its tags are valid.
- blk_ready  in  1  downstream accepts the word when blk_valid and blk_ready are both high on a clk edge.
- blk_word  out  32  current stream word.
- blk_idx  out  4  word index within the block, 0..15.
- blk_last  out  1  high when blk_idx == 15.
- msg_last  out  1  high on the final word of the final block.

## Operation
- NB = number of blocks = floor((32*N + 64) / 512) + 1, where N = NUM_OF_WORDS. Total stream length is T = 16*NB words.
- Stream word w, for w in 0..T-1, is defined as follows:
  - w < N: mem[message_addr + w].
  - w == N: 0x80000000.
  - w == T-2: upper 32 bits of the 64-bit length L = 32*N.
  - w == T-1: lower 32 bits of L.
  - otherwise: 0.
- Address arithmetic is 16-bit and wraps modulo 2^16. The word counter w is 16 bits. blk_idx = w[3:0].
- FSM states:
  - IDLE: start high → latch message_addr, clear w, go to REQ. Otherwise stay.
  - REQ:
    - If w < N: drive mem_addr = message_addr + w, go to CAP.
    - Otherwise: load the pad or length word into the output register, go to EMIT.
  - CAP: register mem_read_data into the output register, go to EMIT.
  - EMIT: blk_valid = 1. On handshake:
    - If w == T-1: pulse done, go to IDLE.
    - Otherwise: w++ and go to REQ.
- blk_word, blk_idx, blk_last and msg_last are registered. They stay stable while blk_valid is high and blk_ready is low.
- start is ignored outside IDLE; there is no queuing.
- blk_ready is ignored while blk_valid is low.

## Timing
- Reset values:
  - state = IDLE.
  - blk_valid = 0, done = 0, mem_we = 0, mem_addr = 0.
  - blk_word = 0, blk_idx = 0, blk_last = 0, msg_last = 0.
  - w = 0.
- Reset assertion mid-stream drops blk_valid asynchronously and abandons the message. No done pulse is issued.
- mem_addr equals 0 in every state other than REQ with w < N.
- Start accepted on edge k. A message word is presented on blk_valid at edge k+3.
  - Message word: 3 cycles per word with blk_ready held high (REQ, CAP, EMIT).
  - Pad or length word: 2 cycles per word (REQ, EMIT).
- done is high for exactly one cycle, the cycle after the final handshake. The block is in IDLE that same cycle and accepts a start there.
- Back-to-back messages: start asserted on the done cycle is accepted.

## Test plan
- N=20, message words 0x00000001..0x00000014, blk_ready=1 → 32 words.
  - Words 0..19 match memory, word 20 = 0x80000000, words 21..29 = 0.
  - Word 30 = 0, word 31 = 0x00000280.
  - blk_last on words 15 and 31, msg_last only on word 31, one done pulse.
- N=13 → 16 words (NB=1).
  - Word 13 = 0x80000000, word 14 = 0, word 15 = 0x000001A0, msg_last on word 15.
- N=14 (padding boundary) → 32 words.
  - Word 14 = 0x80000000, words 15..30 = 0, word 31 = 0x000001C0.
- N=16 (exact block) → 32 words.
  - Word 16 = 0x80000000, word 31 = 0x00000200, blk_idx of word 16 = 0.
- Backpressure: hold blk_ready low for 5 cycles on word 3, then on word 20.
  - blk_word, blk_idx and blk_valid stay stable throughout; no word is lost or duplicated.
- Reset mid-stream at word 7, then start with message_addr=0xFFFE and N=20.
  - blk_valid drops immediately on reset.
  - The new stream reads addresses 0xFFFE, 0xFFFF, 0x0000... (wrap).
  - A start pulse issued while busy is ignored; exactly one done pulse follows.
